// File: rtl/idma_obi_read_tracker.sv
// ---------------------------------------------------------------------------
// idma_obi_read_tracker
//
// Turns legalized one-word read requests into OBI A-channel transactions,
// tracks the beats that have been granted but not yet consumed, and streams
// the R-channel responses out as byte-strobed beats. One request is exactly
// one OBI beat.
//
// Optional build macro: IDMA_OBI_READ_ERR_EN adds obi_err_i / rd_err_o. An
// errored beat is still delivered, but with rd_strb_o forced to zero.
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   req_*                     legalizer read request (valid/ready, addr, aid,
//                             first valid lane, one-past-last lane)
//   obi_req_o/obi_gnt_i       OBI A-channel handshake with obi_addr_o/obi_aid_o
//   obi_rvalid_i/obi_rdata_i  OBI R-channel (no back-pressure)
//   rd_*                      read stream (valid/ready, data, byte strobe)
//   busy_o                    any beat in the A-slot, in flight or buffered
// ---------------------------------------------------------------------------
module idma_obi_read_tracker #(
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned IdWidth        = 1,
    parameter int unsigned NumOutstanding = 2,
    localparam int unsigned StrbWidth     = DataWidth / 8,
    localparam int unsigned OffsetWidth   = $clog2(StrbWidth)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [AddrWidth-1:0]   req_addr_i,
    input  logic [IdWidth-1:0]     req_aid_i,
    input  logic [OffsetWidth-1:0] req_offset_i,
    input  logic [OffsetWidth-1:0] req_tailer_i,
    output logic                   obi_req_o,
    input  logic                   obi_gnt_i,
    output logic [AddrWidth-1:0]   obi_addr_o,
    output logic [IdWidth-1:0]     obi_aid_o,
    input  logic                   obi_rvalid_i,
    input  logic [DataWidth-1:0]   obi_rdata_i,
    output logic                   rd_valid_o,
    input  logic                   rd_ready_i,
    output logic [DataWidth-1:0]   rd_data_o,
    output logic [StrbWidth-1:0]   rd_strb_o,
    output logic                   busy_o
`ifdef IDMA_OBI_READ_ERR_EN
    ,
    input  logic                   obi_err_i,
    output logic                   rd_err_o
`endif
);

    localparam int unsigned PtrWidth = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1;
    localparam int unsigned CntWidth = $clog2(NumOutstanding + 1);
`ifdef IDMA_OBI_READ_ERR_EN
    localparam int unsigned EntryWidth = DataWidth + 1;
`else
    localparam int unsigned EntryWidth = DataWidth;
`endif

    typedef logic [PtrWidth-1:0] ptr_t;
    typedef logic [CntWidth-1:0] cnt_t;
    typedef enum logic {ST_IDLE, ST_REQ} state_e;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(NumOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [StrbWidth-1:0] calc_strb(input logic [OffsetWidth-1:0] off,
                                                       input logic [OffsetWidth-1:0] tail);
        logic [StrbWidth-1:0] s;
        s = '0;
        for (int unsigned i = 0; i < StrbWidth; i++) begin
            s[i] = (i >= 32'(off)) && ((tail == '0) || (i < 32'(tail)));
        end
        return s;
    endfunction

    // A-slot
    state_e                 state_q, state_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [IdWidth-1:0]     aid_q, aid_d;
    logic [StrbWidth-1:0]   strb_q, strb_d;
    logic                   ready_en_q;

    // Strobe FIFO (one entry per granted beat) and response FIFO
    logic [StrbWidth-1:0]   strb_mem_q [NumOutstanding];
    ptr_t                   strb_wr_ptr_q, strb_rd_ptr_q;
    cnt_t                   strb_cnt_q;
    logic [EntryWidth-1:0]  data_mem_q [NumOutstanding];
    ptr_t                   data_wr_ptr_q, data_rd_ptr_q;
    cnt_t                   data_cnt_q;

    logic                   accept, grant, pop, push_data, credit_ok;
    cnt_t                   outstanding;
    logic [CntWidth:0]      used;
    logic [EntryWidth-1:0]  entry_in, entry_head;
    logic                   head_err;

    assign grant       = (state_q == ST_REQ) & obi_gnt_i;
    assign pop         = rd_valid_o & rd_ready_i;
    assign accept      = req_valid_i & req_ready_o;
    // Every strobe entry is either still awaiting its response or sits in the
    // response FIFO, so the difference is the granted-awaiting-response count.
    assign outstanding = strb_cnt_q - data_cnt_q;
    // A response with nothing outstanding is a protocol error; drop it.
    assign push_data   = obi_rvalid_i & (outstanding != '0);

    // Occupancy after this cycle's consumer pop; a beat moving from the A-slot
    // into the outstanding set on grant is counted once either way.
    assign used      = {1'b0, strb_cnt_q} + {{CntWidth{1'b0}}, state_q == ST_REQ}
                     - {{CntWidth{1'b0}}, pop};
    assign credit_ok = used < (CntWidth + 1)'(NumOutstanding);

    assign req_ready_o = ready_en_q & ((state_q == ST_IDLE) | obi_gnt_i) & credit_ok;
    assign obi_req_o   = (state_q == ST_REQ);
    assign obi_addr_o  = addr_q;
    assign obi_aid_o   = aid_q;

    // NOTE: every signal driven here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        aid_d   = aid_q;
        strb_d  = strb_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_REQ;
            ST_REQ:  if (obi_gnt_i) state_d = accept ? ST_REQ : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Acceptance only happens while idle or in the grant cycle, so the
        // presented address/id never change during a stalled request.
        if (accept) begin
            addr_d = req_addr_i;
            aid_d  = req_aid_i;
            strb_d = calc_strb(req_offset_i, req_tailer_i);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            aid_q         <= '0;
            strb_q        <= '0;
            ready_en_q    <= 1'b0;
            strb_wr_ptr_q <= '0;
            strb_rd_ptr_q <= '0;
            strb_cnt_q    <= '0;
            data_wr_ptr_q <= '0;
            data_rd_ptr_q <= '0;
            data_cnt_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            aid_q      <= aid_d;
            strb_q     <= strb_d;
            ready_en_q <= 1'b1;
            if (grant) strb_wr_ptr_q <= ptr_inc(strb_wr_ptr_q);
            if (pop)   strb_rd_ptr_q <= ptr_inc(strb_rd_ptr_q);
            if (push_data) data_wr_ptr_q <= ptr_inc(data_wr_ptr_q);
            if (pop)       data_rd_ptr_q <= ptr_inc(data_rd_ptr_q);
            case ({grant, pop})
                2'b10:   strb_cnt_q <= strb_cnt_q + 1'b1;
                2'b01:   strb_cnt_q <= strb_cnt_q - 1'b1;
                default: strb_cnt_q <= strb_cnt_q;
            endcase
            case ({push_data, pop})
                2'b10:   data_cnt_q <= data_cnt_q + 1'b1;
                2'b01:   data_cnt_q <= data_cnt_q - 1'b1;
                default: data_cnt_q <= data_cnt_q;
            endcase
        end
    end

`ifdef IDMA_OBI_READ_ERR_EN
    assign entry_in = {obi_err_i, obi_rdata_i};
`else
    assign entry_in = obi_rdata_i;
`endif

    // NOTE: FIFO storage is not reset; the reset pointers and counts alone
    // decide which entries are valid, so stale contents are never visible.
    always_ff @(posedge clk_i) begin
        if (grant)     strb_mem_q[strb_wr_ptr_q] <= strb_q;
        if (push_data) data_mem_q[data_wr_ptr_q] <= entry_in;
    end

    assign entry_head = data_mem_q[data_rd_ptr_q];
    assign rd_valid_o = (data_cnt_q != '0);
    assign rd_data_o  = entry_head[DataWidth-1:0];
`ifdef IDMA_OBI_READ_ERR_EN
    assign head_err   = entry_head[DataWidth];
    assign rd_err_o   = head_err;
`else
    assign head_err   = 1'b0;
`endif
    assign rd_strb_o  = head_err ? '0 : strb_mem_q[strb_rd_ptr_q];

    assign busy_o = (state_q == ST_REQ) | (outstanding != '0) | (data_cnt_q != '0);

    rvalid_needs_outstanding: assert property (
        @(posedge clk_i) disable iff (!rst_ni) obi_rvalid_i |-> (outstanding != '0));

endmodule

// File: tb/tb_idma_obi_read_tracker.sv
module tb_idma_obi_read_tracker;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b1;
    always #5 clk_i = ~clk_i;

    // DUT with NumOutstanding = 2
    logic        req_valid_i, req_ready_o, req_aid_i, obi_req_o, obi_gnt_i, obi_aid_o;
    logic [31:0] req_addr_i, obi_addr_o, obi_rdata_i, rd_data_o;
    logic [1:0]  req_offset_i, req_tailer_i;
    logic        obi_rvalid_i, rd_valid_o, rd_ready_i, busy_o;
    logic [3:0]  rd_strb_o;
    // Throughput DUT with NumOutstanding = 4
    logic        t_req_valid_i, t_req_ready_o, t_req_aid_i, t_obi_req_o, t_obi_gnt_i, t_obi_aid_o;
    logic [31:0] t_req_addr_i, t_obi_addr_o, t_obi_rdata_i, t_rd_data_o;
    logic [1:0]  t_req_offset_i, t_req_tailer_i;
    logic        t_obi_rvalid_i, t_rd_valid_o, t_rd_ready_i, t_busy_o;
    logic [3:0]  t_rd_strb_o;
`ifdef IDMA_OBI_READ_ERR_EN
    logic obi_err_i, rd_err_o, t_obi_err_i, t_rd_err_o;
`endif

    idma_obi_read_tracker #(.NumOutstanding(2)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .req_aid_i(req_aid_i), .req_offset_i(req_offset_i), .req_tailer_i(req_tailer_i),
        .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o),
        .obi_aid_o(obi_aid_o), .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i),
        .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o),
        .rd_strb_o(rd_strb_o), .busy_o(busy_o)
`ifdef IDMA_OBI_READ_ERR_EN
        , .obi_err_i(obi_err_i), .rd_err_o(rd_err_o)
`endif
    );

    idma_obi_read_tracker #(.NumOutstanding(4)) u_dut_t (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(t_req_valid_i), .req_ready_o(t_req_ready_o), .req_addr_i(t_req_addr_i),
        .req_aid_i(t_req_aid_i), .req_offset_i(t_req_offset_i), .req_tailer_i(t_req_tailer_i),
        .obi_req_o(t_obi_req_o), .obi_gnt_i(t_obi_gnt_i), .obi_addr_o(t_obi_addr_o),
        .obi_aid_o(t_obi_aid_o), .obi_rvalid_i(t_obi_rvalid_i), .obi_rdata_i(t_obi_rdata_i),
        .rd_valid_o(t_rd_valid_o), .rd_ready_i(t_rd_ready_i), .rd_data_o(t_rd_data_o),
        .rd_strb_o(t_rd_strb_o), .busy_o(t_busy_o)
`ifdef IDMA_OBI_READ_ERR_EN
        , .obi_err_i(t_obi_err_i), .rd_err_o(t_rd_err_o)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One complete read on the N=2 DUT: accept, gnt next cycle, rvalid two
    // cycles after gnt, consume on the first visible cycle.
    task automatic do_read(input string tag, input logic [31:0] addr, input logic [1:0] off,
                           input logic [1:0] tail, input logic [31:0] data,
                           input logic [3:0] exp_strb, input logic err);
        req_valid_i = 1'b1; req_addr_i = addr; req_offset_i = off; req_tailer_i = tail;
        req_aid_i = 1'b1;
        #1;
        check({tag, " ready"}, req_ready_o, 1);
        check({tag, " req idle"}, obi_req_o, 0);
        @(negedge clk_i);
        req_valid_i = 1'b0; obi_gnt_i = 1'b1;
        #1;
        check({tag, " req"}, obi_req_o, 1);
        check({tag, " addr"}, obi_addr_o, addr);
        check({tag, " aid"}, obi_aid_o, 1);
        check({tag, " busy"}, busy_o, 1);
        @(negedge clk_i);
        obi_gnt_i = 1'b0;
        #1;
        check({tag, " req drop"}, obi_req_o, 0);
        check({tag, " busy pend"}, busy_o, 1);
        @(negedge clk_i);
        obi_rvalid_i = 1'b1; obi_rdata_i = data;
`ifdef IDMA_OBI_READ_ERR_EN
        obi_err_i = err;
`endif
        #1;
        check({tag, " no fallthru"}, rd_valid_o, 0);
        @(negedge clk_i);
        obi_rvalid_i = 1'b0; rd_ready_i = 1'b1;
`ifdef IDMA_OBI_READ_ERR_EN
        obi_err_i = 1'b0;
        #1;
        check({tag, " err"}, rd_err_o, err);
`else
        #1;
`endif
        check({tag, " rd_valid"}, rd_valid_o, 1);
        check({tag, " data"}, rd_data_o, data);
        check({tag, " strb"}, rd_strb_o, err ? 4'h0 : exp_strb);
        @(negedge clk_i);
        rd_ready_i = 1'b0;
        #1;
        check({tag, " rd drained"}, rd_valid_o, 0);
        check({tag, " idle busy"}, busy_o, 0);
        @(negedge clk_i);
    endtask

    // Credit-limit scenario table, one entry per cycle (-1 = not checked / none)
    int          cl_rv     [11] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    int          cl_ridx   [11] = '{0, 1, 2, 2, 2, 2, 3, 3, 3, 3, 3};
    int          cl_rsp    [11] = '{-1, -1, 0, 1, -1, -1, -1, 2, 3, -1, -1};
    int          cl_rdr    [11] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    int          cl_ready  [11] = '{1, 1, 0, 0, 0, 1, 1, 0, 1, 1, 1};
    int          cl_oreq   [11] = '{0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
    int          cl_oaddr  [11] = '{-1, 0, 1, -1, -1, -1, 2, 3, -1, -1, -1};
    int          cl_beat   [11] = '{-1, -1, -1, 0, 0, 0, 1, -1, 2, 3, -1};
    int          cl_busy   [11] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    logic [1:0]  cl_off    [4]  = '{2'd0, 2'd1, 2'd0, 2'd3};
    logic [1:0]  cl_tail   [4]  = '{2'd0, 2'd0, 2'd2, 2'd0};
    logic [3:0]  cl_strb   [4]  = '{4'hF, 4'hE, 4'h3, 4'h8};
    logic [31:0] cl_data   [4]  = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};

    localparam int K = 8;

    initial begin
        req_valid_i = 0; req_addr_i = 0; req_aid_i = 0; req_offset_i = 0; req_tailer_i = 0;
        obi_gnt_i = 0; obi_rvalid_i = 0; obi_rdata_i = 0; rd_ready_i = 0;
        t_req_valid_i = 0; t_req_addr_i = 0; t_req_aid_i = 0; t_req_offset_i = 0;
        t_req_tailer_i = 0; t_obi_gnt_i = 0; t_obi_rvalid_i = 0; t_obi_rdata_i = 0;
        t_rd_ready_i = 0;
`ifdef IDMA_OBI_READ_ERR_EN
        obi_err_i = 0; t_obi_err_i = 0;
`endif
        #2 rst_ni = 1'b0;

        // Reset state
        @(negedge clk_i);
        #1;
        check("rst obi_req", obi_req_o, 0);
        check("rst rd_valid", rd_valid_o, 0);
        check("rst busy", busy_o, 0);
        check("rst ready", req_ready_o, 0);
        check("rst addr", obi_addr_o, 0);
        check("rst aid", obi_aid_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        #1;
        check("post-rst ready", req_ready_o, 1);
        check("post-rst busy", busy_o, 0);
        @(negedge clk_i);

        // Single read and partial lanes
        do_read("single", 32'h0000_0100, 2'd0, 2'd0, 32'hDEAD_BEEF, 4'hF, 1'b0);
        do_read("lanes13", 32'h0000_0104, 2'd1, 2'd3, 32'h0102_0304, 4'b0110, 1'b0);
        do_read("lanes20", 32'h0000_0108, 2'd2, 2'd0, 32'hCAFE_F00D, 4'b1100, 1'b0);

        // Grant stall: address must hold while the new request input changes
        req_valid_i = 1'b1; req_addr_i = 32'h0000_0200; req_offset_i = 0; req_tailer_i = 0;
        #1;
        check("stall accept", req_ready_o, 1);
        @(negedge clk_i);
        req_valid_i = 1'b0; req_addr_i = 32'h0000_0BAD;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("stall req c%0d", i), obi_req_o, 1);
            check($sformatf("stall addr c%0d", i), obi_addr_o, 32'h0000_0200);
            check($sformatf("stall ready c%0d", i), req_ready_o, 0);
            @(negedge clk_i);
        end
        obi_gnt_i = 1'b1;
        #1;
        check("stall gnt ready", req_ready_o, 1);
        check("stall gnt addr", obi_addr_o, 32'h0000_0200);
        @(negedge clk_i);
        obi_gnt_i = 1'b0; obi_rvalid_i = 1'b1; obi_rdata_i = 32'h5A5A_A5A5;
        #1;
        check("stall req drop", obi_req_o, 0);
        @(negedge clk_i);
        obi_rvalid_i = 1'b0; rd_ready_i = 1'b1;
        #1;
        check("stall rd_valid", rd_valid_o, 1);
        check("stall data", rd_data_o, 32'h5A5A_A5A5);
        @(negedge clk_i);
        rd_ready_i = 1'b0;
        #1;
        check("stall idle busy", busy_o, 0);
        @(negedge clk_i);

        // Credit limit with NumOutstanding = 2
        obi_gnt_i = 1'b1;
        for (int c = 0; c < 11; c++) begin
            req_valid_i  = cl_rv[c][0];
            req_addr_i   = 32'h0000_0300 + 32'(4 * cl_ridx[c]);
            req_offset_i = cl_off[cl_ridx[c]];
            req_tailer_i = cl_tail[cl_ridx[c]];
            obi_rvalid_i = (cl_rsp[c] >= 0);
            obi_rdata_i  = (cl_rsp[c] >= 0) ? cl_data[cl_rsp[c]] : 32'h0;
            rd_ready_i   = cl_rdr[c][0];
            #1;
            check($sformatf("credit ready c%0d", c), req_ready_o, cl_ready[c]);
            check($sformatf("credit oreq c%0d", c), obi_req_o, cl_oreq[c]);
            check($sformatf("credit busy c%0d", c), busy_o, cl_busy[c]);
            check($sformatf("credit rdv c%0d", c), rd_valid_o, cl_beat[c] >= 0);
            if (cl_oaddr[c] >= 0)
                check($sformatf("credit oaddr c%0d", c), obi_addr_o,
                      32'h0000_0300 + 32'(4 * cl_oaddr[c]));
            if (cl_beat[c] >= 0) begin
                check($sformatf("credit data c%0d", c), rd_data_o, cl_data[cl_beat[c]]);
                check($sformatf("credit strb c%0d", c), rd_strb_o, cl_strb[cl_beat[c]]);
            end
            @(negedge clk_i);
        end
        req_valid_i = 0; obi_gnt_i = 0; obi_rvalid_i = 0; rd_ready_i = 0;

        // Full throughput on the NumOutstanding = 4 instance
        t_obi_gnt_i = 1'b1; t_rd_ready_i = 1'b1;
        for (int c = 0; c < K + 4; c++) begin
            t_req_valid_i  = (c < K);
            t_req_addr_i   = 32'h0000_1000 + 32'(4 * c);
            t_obi_rvalid_i = (c >= 2) && (c <= K + 1);
            t_obi_rdata_i  = 32'hA500_0000 + 32'(c - 2);
            #1;
            if (c < K) check($sformatf("thru ready c%0d", c), t_req_ready_o, 1);
            if (c >= 1 && c <= K)
                check($sformatf("thru oaddr c%0d", c), t_obi_addr_o, 32'h0000_1000 + 32'(4 * (c - 1)));
            check($sformatf("thru oreq c%0d", c), t_obi_req_o, (c >= 1) && (c <= K));
            check($sformatf("thru rdv c%0d", c), t_rd_valid_o, (c >= 3) && (c <= K + 2));
            if (c >= 3 && c <= K + 2) begin
                check($sformatf("thru data c%0d", c), t_rd_data_o, 32'hA500_0000 + 32'(c - 3));
                check($sformatf("thru strb c%0d", c), t_rd_strb_o, 4'hF);
            end
            @(negedge clk_i);
        end
        t_req_valid_i = 0; t_obi_gnt_i = 0; t_obi_rvalid_i = 0; t_rd_ready_i = 0;
        #1;
        check("thru idle busy", t_busy_o, 0);
        @(negedge clk_i);

`ifdef IDMA_OBI_READ_ERR_EN
        // Error beat then a clean beat
        do_read("err beat", 32'h0000_0400, 2'd1, 2'd3, 32'hBAD0_0BAD, 4'b0110, 1'b1);
        do_read("clean beat", 32'h0000_0404, 2'd0, 2'd0, 32'h600D_600D, 4'hF, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/idma_obi_read_tracker.md
Name: idma_obi_read_tracker

Overview:
- Downstream consumer of the OBI/TXRX legalizer's read request port (r_req_o/r_valid_o/r_ready_i).
- Converts each legalized one-word read request into one OBI A-channel transaction and tracks outstanding transactions.
- Buffers R-channel responses and emits a byte-strobed read stream to the dataflow element.
- Implementation: one legal request equals exactly one OBI beat (page size equals word size).

Parameters:
- DataWidth, 32, OBI data width in bits; StrbWidth = DataWidth/8, OffsetWidth = $clog2(StrbWidth).
- AddrWidth, 32, OBI address width.
- IdWidth, 1, OBI aid/rid width.
- NumOutstanding, 2, maximum issued-but-unconsumed beats; power of two, >= 1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active low
- req_valid_i  in  1  legalizer read request valid
- req_ready_o  out  1  request accepted; must not depend on req_valid_i
- req_addr_i  in  AddrWidth  word-aligned read address
- req_aid_i  in  IdWidth  transaction id
- req_offset_i  in  OffsetWidth  first valid byte lane
- req_tailer_i  in  OffsetWidth  one past last valid lane; 0 means up to the top lane
- obi_req_o  out  1  OBI A-channel request
- obi_gnt_i  in  1  OBI grant
- obi_addr_o  out  AddrWidth  OBI address
- obi_aid_o  out  IdWidth  OBI id
- obi_rvalid_i  in  1  OBI response valid; no back-pressure possible
- obi_rdata_i  in  DataWidth  OBI response data
- rd_valid_o  out  1  read stream beat valid
- rd_ready_i  in  1  read stream ready
- rd_data_o  out  DataWidth  beat data
- rd_strb_o  out  StrbWidth  valid byte lanes of beat
- busy_o  out  1  any transaction issued, pending or buffered

Behaviour:
- Reset: obi_req_o = 0, rd_valid_o = 0, busy_o = 0, req_ready_o = 0 during reset and 1 on the first cycle after; all counters and FIFOs empty; obi_addr_o/obi_aid_o = 0.
- A-slot FSM, two states.
  - IDLE: obi_req_o = 0. On req_valid_i & req_ready_o, latch addr and aid, compute strb, go to REQ.
  - REQ: obi_req_o = 1, with address and id held stable until obi_gnt_i. On gnt, go to IDLE, or stay in REQ if a new request is accepted in the same cycle (back-to-back, one beat per cycle).
- Credits: credit = NumOutstanding - (A-slot occupied + granted-awaiting-response + response FIFO occupancy).
  - req_ready_o = (state==IDLE | obi_gnt_i) & (credit > 0 counting a beat that is leaving via rd_valid_o & rd_ready_i in the same cycle).
  - This guarantees response FIFO space for every rvalid, so obi_rvalid_i is never dropped.
- Strobe rule: strb[i] = (i >= offset) & (tailer==0 | i < tailer).
  - Example, offset=1, tailer=3 (StrbWidth 4): 4'b0110.
  - offset=0, tailer=0: all ones.
- Strb FIFO, depth NumOutstanding: pushed on grant, popped on stream handshake.
- Data FIFO, depth NumOutstanding: pushed on obi_rvalid_i.
- rd_valid_o = data FIFO not empty; rd_strb_o = strb FIFO head. Responses are in order (OBI); rid is ignored.
- Latency: gnt in the cycle after acceptance gives earliest rd_valid_o one cycle after rvalid (registered FIFO output). Fall-through is not allowed.
- Simultaneous push/pop on a full FIFO is legal and keeps occupancy constant.
- obi_rvalid_i with zero granted-outstanding count is a protocol error: assertion, and data is discarded.
- busy_o = (state==REQ) | outstanding count != 0 | data FIFO not empty.
- Reset mid-operation: all state is cleared asynchronously and in-flight responses are forgotten; the interconnect is reset by the same rst_ni.

Optional Feature:
- Macro IDMA_OBI_READ_ERR_EN.
- Defined:
  - Adds input obi_err_i (1, qualified by obi_rvalid_i) and output rd_err_o (1, aligned with rd_valid_o).
  - The err bit is stored alongside the data in the data FIFO.
  - An errored beat is still delivered, with rd_strb_o forced to 0.
- Not defined: ports absent; every beat is error-free.

Test Plan:
- Single read (DataWidth 32): req addr 0x100, offset 0, tailer 0; gnt immediate; rvalid 2 cycles later with 0xDEADBEEF -> one rd beat with data 0xDEADBEEF, strb 4'hF; busy_o falls after the handshake.
- Partial lanes: offset 1, tailer 3 -> rd_strb_o 4'b0110; offset 2, tailer 0 -> 4'b1100.
- Grant stall: gnt held low 5 cycles -> obi_req_o high with obi_addr_o stable the whole time; req_ready_o low until the gnt cycle.
- Credit limit (NumOutstanding 2, rd_ready_i=0): 4 back-to-back requests, immediate gnt and rvalid -> exactly 2 granted and req_ready_o stays 0. Raise rd_ready_i -> remaining 2 issue, and all 4 beats emerge in order with matching strobes.
- Full throughput: rd_ready_i=1, gnt and rvalid every cycle -> one rd beat per cycle sustained, no dropped rvalid.
- Error path (IDMA_OBI_READ_ERR_EN defined): rvalid with obi_err_i=1 -> rd_err_o=1, rd_strb_o=0 on that beat only; the next beat is clean.
